// File: rtl/aes128_pkg.sv
// Shared AES-128 widths, padding constants and packer state encoding.
// Imported by the block packer and its padding helper.
package aes128_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_WORD_W      = 32;
  localparam int WORDS_PER_BLOCK = 4;

  localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_OUT  = 2'd1,
    ST_PAD  = 2'd2
  } pk_state_e;

  // Last-word byte count: 0 or anything above 4 means a full word.
  function automatic logic [2:0] eff_nbytes(input logic [2:0] n);
    return ((n == 3'd0) || (n > 3'd4)) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/aes128_pkcs7_word_pad.sv
// Merges the valid low bytes of one word with a fill byte above them.
// Fully combinational.
module aes128_pkcs7_word_pad
  import aes128_pkg::*;
(
  input  logic [AES_WORD_W-1:0] word,
  input  logic [2:0]            nbytes,
  input  logic [7:0]            pad_byte,
  output logic [AES_WORD_W-1:0] merged
);

  always_comb begin
    merged = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < nbytes)
        merged[8*j +: 8] = word[8*j +: 8];
      else
        merged[8*j +: 8] = pad_byte;
    end
  end

endmodule

// File: rtl/aes128_cbc_block_packer.sv
// Packs a 32-bit word stream into 128-bit AES blocks with
// PKCS#7 (or zero) padding of the final block.
module aes128_cbc_block_packer
  import aes128_pkg::*;
#(
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AES_WORD_W-1:0] in_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            in_nbytes,
  output logic [AES_WORD_W-1:0] plain_text_0,
  output logic [AES_WORD_W-1:0] plain_text_1,
  output logic [AES_WORD_W-1:0] plain_text_2,
  output logic [AES_WORD_W-1:0] plain_text_3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [CNT_W-1:0]      blk_count
);

  pk_state_e state_q, state_d;

  logic [1:0] idx_q, idx_d;
  logic [AES_WORD_W-1:0] pt_q [WORDS_PER_BLOCK];
  logic [AES_WORD_W-1:0] pt_d [WORDS_PER_BLOCK];

  logic vld_q, vld_d;
  logic last_q, last_d;
  logic padp_q, padp_d;
  logic clr_q, clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic hs;
  logic [2:0] nb_eff;
  logic [2:0] nb_word;
  logic [4:0] n_bytes;
  logic [4:0] pad_len;
  logic [7:0] pad_byte;
  logic [AES_WORD_W-1:0] merged;
  logic [AES_WORD_W-1:0] fill_word;

  assign in_ready  = (state_q == ST_FILL);
  assign accept    = in_valid && in_ready;
  assign hs        = vld_q && out_ready;

  assign nb_eff    = eff_nbytes(in_nbytes);
  assign nb_word   = in_last ? nb_eff : 3'd4;
  assign n_bytes   = {1'b0, idx_q, 2'b00} + {2'b00, nb_eff};
  assign pad_len   = 5'd16 - n_bytes;
  assign pad_byte  = PAD_EN ? {3'b000, pad_len} : 8'h00;
  assign fill_word = {4{pad_byte}};

  aes128_pkcs7_word_pad u_word_pad (
    .word     (in_word),
    .nbytes   (nb_word),
    .pad_byte (pad_byte),
    .merged   (merged)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pt_d    = pt_q;
    vld_d   = vld_q;
    last_d  = last_q;
    padp_d  = padp_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (clr_q) begin
            cnt_d = '0;
            clr_d = 1'b0;
          end
          pt_d[idx_q] = merged;
          if (in_last) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
              if (k > int'(idx_q))
                pt_d[k] = fill_word;
            end
            vld_d   = 1'b1;
            idx_d   = 2'd0;
            state_d = ST_OUT;
            // A message that ends on a block boundary owes a full pad block.
            if (PAD_EN && (n_bytes == 5'd16)) begin
              last_d = 1'b0;
              padp_d = 1'b1;
            end else begin
              last_d = 1'b1;
            end
          end else if (idx_q == 2'd3) begin
            vld_d   = 1'b1;
            last_d  = 1'b0;
            idx_d   = 2'd0;
            state_d = ST_OUT;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_OUT: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (padp_q) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++)
              pt_d[k] = {4{PKCS7_FULL_PAD}};
            last_d  = 1'b1;
            padp_d  = 1'b0;
            state_d = ST_PAD;
          end else begin
            vld_d   = 1'b0;
            clr_d   = last_q;
            state_d = ST_FILL;
          end
        end
      end
      ST_PAD: begin
        if (hs) begin
          cnt_d   = cnt_q + 1'b1;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          clr_d   = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
      idx_q   <= 2'd0;
      for (int k = 0; k < WORDS_PER_BLOCK; k++)
        pt_q[k] <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      padp_q  <= 1'b0;
      clr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int k = 0; k < WORDS_PER_BLOCK; k++)
        pt_q[k] <= pt_d[k];
      vld_q   <= vld_d;
      last_q  <= last_d;
      padp_q  <= padp_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign plain_text_0 = pt_q[0];
  assign plain_text_1 = pt_q[1];
  assign plain_text_2 = pt_q[2];
  assign plain_text_3 = pt_q[3];
  assign out_valid    = vld_q;
  assign out_last     = last_q;
  assign blk_count    = cnt_q;

endmodule

// File: tb/tb_aes128_cbc_block_packer.sv
// Directed bench for the AES-128 block packer, covering the
// PKCS#7 and zero-fill builds side by side.
module tb_aes128_cbc_block_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  in_nbytes = '0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] p_pt0, p_pt1, p_pt2, p_pt3;
  logic [31:0] z_pt0, z_pt1, z_pt2, z_pt3;
  logic        p_in_ready, p_out_valid, p_out_last;
  logic        z_in_ready, z_out_valid, z_out_last;
  logic [15:0] p_cnt, z_cnt;

  logic [127:0] blk;
  logic         in_ready, out_valid, out_last;
  logic [15:0]  blk_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes128_cbc_block_packer #(.PAD_EN(1'b1), .CNT_W(16)) u_pad (
    .clk          (clk),
    .reset        (reset),
    .in_word      (in_word),
    .in_valid     (in_valid && !sel),
    .in_ready     (p_in_ready),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes),
    .plain_text_0 (p_pt0),
    .plain_text_1 (p_pt1),
    .plain_text_2 (p_pt2),
    .plain_text_3 (p_pt3),
    .out_valid    (p_out_valid),
    .out_ready    (out_ready && !sel),
    .out_last     (p_out_last),
    .blk_count    (p_cnt)
  );

  aes128_cbc_block_packer #(.PAD_EN(1'b0), .CNT_W(16)) u_zero (
    .clk          (clk),
    .reset        (reset),
    .in_word      (in_word),
    .in_valid     (in_valid && sel),
    .in_ready     (z_in_ready),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes),
    .plain_text_0 (z_pt0),
    .plain_text_1 (z_pt1),
    .plain_text_2 (z_pt2),
    .plain_text_3 (z_pt3),
    .out_valid    (z_out_valid),
    .out_ready    (out_ready && sel),
    .out_last     (z_out_last),
    .blk_count    (z_cnt)
  );

  assign blk       = sel ? {z_pt3, z_pt2, z_pt1, z_pt0}
                         : {p_pt3, p_pt2, p_pt1, p_pt0};
  assign in_ready  = sel ? z_in_ready : p_in_ready;
  assign out_valid = sel ? z_out_valid : p_out_valid;
  assign out_last  = sel ? z_out_last : p_out_last;
  assign blk_count = sel ? z_cnt : p_cnt;

  task automatic send(input logic [31:0] w, input logic last,
                      input logic [2:0] nb);
    int guard = 0;
    in_word   = w;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string nm, input logic [127:0] exp,
                      input logic exp_last);
    int guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_valid: got %b required 1", nm, out_valid);
    end
    tests++;
    if (blk !== exp) begin
      fails++;
      $display("FAIL %s_data: got %h required %h", nm, blk, exp);
    end
    tests++;
    if (out_last !== exp_last) begin
      fails++;
      $display("FAIL %s_last: got %b required %b", nm, out_last, exp_last);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({p_out_valid, p_out_last, z_out_valid, z_out_last} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b%b%b%b required 0000",
               p_out_valid, p_out_last, z_out_valid, z_out_last);
    end
    tests++;
    if ({p_pt3, p_pt2, p_pt1, p_pt0} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0",
               {p_pt3, p_pt2, p_pt1, p_pt0});
    end
    tests++;
    if ({p_cnt, z_cnt} !== 32'h0 || {p_in_ready, z_in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_cnt_ready: cnt=%h/%h rdy=%b%b required 0/0 11",
               p_cnt, z_cnt, p_in_ready, z_in_ready);
    end
  endtask

  task automatic test_full_pad();
    sel = 1'b0;
    send(32'h6f6e6f43, 1'b0, 3'd0);
    send(32'h6f4e2072, 1'b0, 3'd0);
    send(32'h206e616c, 1'b0, 3'd0);
    send(32'h54494d47, 1'b1, 3'd4);
    take("full_blk0",
         128'h54494d47_206e616c_6f4e2072_6f6e6f43, 1'b0);
    take("full_pad",
         128'h10101010_10101010_10101010_10101010, 1'b1);
    tests++;
    if (blk_count !== 16'd2 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_count: cnt=%0d vld=%b required 2 0",
               blk_count, out_valid);
    end
  endtask

  task automatic test_13_bytes();
    sel = 1'b0;
    send(32'h6f6e6f43, 1'b0, 3'd0);
    tests++;
    if (blk_count !== 16'd0) begin
      fails++;
      $display("FAIL count_clear: got %0d required 0", blk_count);
    end
    send(32'h6f4e2072, 1'b0, 3'd0);
    send(32'h206e616c, 1'b0, 3'd0);
    send(32'h00000047, 1'b1, 3'd1);
    take("b13", 128'h03030347_206e616c_6f4e2072_6f6e6f43, 1'b1);
    tests++;
    if (blk_count !== 16'd1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b13_count: cnt=%0d vld=%b required 1 0",
               blk_count, out_valid);
    end
  endtask

  task automatic test_1_byte();
    sel = 1'b0;
    send(32'h00000041, 1'b1, 3'd1);
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b1_latency: vld=%b rdy=%b required 1 0",
               out_valid, in_ready);
    end
    take("b1", 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f41, 1'b1);
  endtask

  task automatic test_nbytes_edge();
    sel = 1'b0;
    send(32'h44332211, 1'b0, 3'd0);
    send(32'h88776655, 1'b1, 3'd0);
    take("nb0", 128'h08080808_08080808_88776655_44332211, 1'b1);
    send(32'h44332211, 1'b0, 3'd0);
    send(32'h00ccbbaa, 1'b1, 3'd3);
    take("nb3", 128'h09090909_09090909_09ccbbaa_44332211, 1'b1);
    send(32'hdeadbeef, 1'b1, 3'd7);
    take("nb7", 128'h0c0c0c0c_0c0c0c0c_0c0c0c0c_deadbeef, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [127:0] exp = 128'hd4c3b2a1_c4b3a291_b4a39281_a4938271;
    sel = 1'b0;
    send(32'ha4938271, 1'b0, 3'd0);
    send(32'hb4a39281, 1'b0, 3'd0);
    send(32'hc4b3a291, 1'b0, 3'd0);
    send(32'hd4c3b2a1, 1'b1, 3'd4);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (blk !== exp || out_last !== 1'b0 || out_valid !== 1'b1 ||
          in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: blk=%h last=%b vld=%b rdy=%b required %h 0 1 0",
                 c, blk, out_last, out_valid, in_ready, exp);
      end
      @(posedge clk); #1;
    end
    take("bp_blk", exp, 1'b0);
    take("bp_pad", 128'h10101010_10101010_10101010_10101010, 1'b1);
  endtask

  task automatic test_zero_fill();
    sel = 1'b1;
    send(32'h6f6e6f43, 1'b0, 3'd0);
    send(32'h00000072, 1'b1, 3'd1);
    take("zf5", 128'h00000000_00000000_00000072_6f6e6f43, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_count !== 16'd1) begin
      fails++;
      $display("FAIL zf_no_extra: vld=%b rdy=%b cnt=%0d required 0 1 1",
               out_valid, in_ready, blk_count);
    end
    send(32'h03020100, 1'b0, 3'd0);
    send(32'h07060504, 1'b0, 3'd0);
    send(32'h0b0a0908, 1'b0, 3'd0);
    send(32'h0f0e0d0c, 1'b1, 3'd4);
    take("zf16", 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1);
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || blk_count !== 16'd1) begin
      fails++;
      $display("FAIL zf16_no_extra: vld=%b cnt=%0d required 0 1",
               out_valid, blk_count);
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    send(32'hbad0bad0, 1'b0, 3'd0);
    send(32'hbad1bad1, 1'b0, 3'd0);
    reset = 1'b0;
    #2;
    tests++;
    if (out_valid !== 1'b0 || blk_count !== 16'd0 || in_ready !== 1'b1 ||
        blk !== 128'h0) begin
      fails++;
      $display("FAIL mid_reset: vld=%b cnt=%0d rdy=%b blk=%h required 0 0 1 0",
               out_valid, blk_count, in_ready, blk);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send(32'h11111111, 1'b0, 3'd0);
    send(32'h22222222, 1'b0, 3'd0);
    send(32'h33333333, 1'b0, 3'd0);
    send(32'h44444444, 1'b1, 3'd4);
    take("post_rst", 128'h44444444_33333333_22222222_11111111, 1'b0);
    take("post_rst_pad", 128'h10101010_10101010_10101010_10101010, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_pad();
    test_13_bytes();
    test_1_byte();
    test_nbytes_edge();
    test_backpressure();
    test_zero_fill();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
